// File: rtl/float_result_buffer_pkg.sv
// Shared float types: exception-flag struct, flag bit positions, float width helper.
package float_result_buffer_pkg;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  localparam int FLAG_W         = 3;
  localparam int FLAG_UNDERFLOW = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_INVALID   = 2;

  function automatic int float_width(input int exp_w, input int man_w);
    return exp_w + man_w + 1;
  endfunction

endpackage

// File: rtl/float_result_buffer_if.sv
// Producer/consumer/control bundle of float_result_buffer; counter signals
// exist only with FLOAT_RESULT_BUFFER_COUNTERS_EN.
interface float_result_buffer_if #(
  parameter int FW = 32,
  parameter int LW = 3
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
  , parameter int CW = 16
`endif
);
  import float_result_buffer_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic          in_underflow;
  logic          in_overflow;
  logic          in_invalid;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;
  fp_flags_t     out_flags;
  logic          flush;
  logic          clear_flags;
  fp_flags_t     sticky_flags;
  logic [LW-1:0] level;
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
  logic [CW-1:0] underflow_count;
  logic [CW-1:0] overflow_count;
  logic [CW-1:0] invalid_count;
`endif

  modport master (
    output in_valid, in_data, in_underflow, in_overflow, in_invalid,
    output out_ready, flush, clear_flags,
    input  in_ready, out_valid, out_data, out_flags, sticky_flags, level
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
    , input underflow_count, overflow_count, invalid_count
`endif
  );

  modport slave (
    input  in_valid, in_data, in_underflow, in_overflow, in_invalid,
    input  out_ready, flush, clear_flags,
    output in_ready, out_valid, out_data, out_flags, sticky_flags, level
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
    , output underflow_count, overflow_count, invalid_count
`endif
  );

endinterface

// File: rtl/float_result_buffer_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, level and flush.
// Latency 1 cycle push-to-head; push refused when full regardless of pop.
module float_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // flush wins over both handshakes in the same cycle
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/float_result_buffer.sv
// Elastic multiplier result FIFO with sticky exception flags; optional
// saturating event counters under FLOAT_RESULT_BUFFER_COUNTERS_EN. 1-cycle latency, in_ready = !full.
module float_result_buffer
  import float_result_buffer_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DEPTH          = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  float_result_buffer_if.slave bus
);

  localparam int FW = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH);
  localparam int EW = FW + FLAG_W;
  localparam int LW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (COUNT_WIDTH < 1)) begin : g_bad_param
    $error("float_result_buffer: DEPTH must be a power of two >= 2, COUNT_WIDTH >= 1");
  end

  logic [FLAG_W-1:0] in_flags;
  logic [EW-1:0]     head_entry;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;
  logic              push_acc;
  logic [FLAG_W-1:0] sticky_q, sticky_d;

  assign in_flags = {bus.in_invalid, bus.in_overflow, bus.in_underflow};
  assign push_acc = bus.in_valid && !fifo_full && !bus.flush;

  float_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .pop_i   (bus.out_ready),
    .flush_i (bus.flush),
    .wdata_i ({in_flags, bus.in_data}),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bus.in_ready     = !fifo_full;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = head_entry[FW-1:0];
  assign bus.out_flags    = fp_flags_t'(head_entry[EW-1:FW]);
  assign bus.level        = fifo_level;
  assign bus.sticky_flags = fp_flags_t'(sticky_q);

  // clear first, then OR in the flags of the push accepted this cycle
  always_comb begin
    sticky_d = bus.clear_flags ? '0 : sticky_q;
    if (push_acc) sticky_d = sticky_d | in_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
  logic [COUNT_WIDTH-1:0] cnt_q [FLAG_W];
  logic [COUNT_WIDTH-1:0] cnt_d [FLAG_W];

  always_comb begin
    for (int i = 0; i < FLAG_W; i++) begin
      cnt_d[i] = bus.clear_flags ? '0 : cnt_q[i];
      if (push_acc && in_flags[i] && (cnt_d[i] != '1)) cnt_d[i] = cnt_d[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLAG_W; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < FLAG_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.underflow_count = cnt_q[FLAG_UNDERFLOW];
  assign bus.overflow_count  = cnt_q[FLAG_OVERFLOW];
  assign bus.invalid_count   = cnt_q[FLAG_INVALID];
`endif

endmodule

// File: tb/tb_float_result_buffer.sv
// Directed bench for float_result_buffer: queue-based reference model checked every cycle plus literal expectations.
module tb_float_result_buffer;
  import float_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  float_result_buffer_if #(
    .FW (32),
    .LW (3)
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
    , .CW (CW)
`endif
  ) bus ();

  float_result_buffer #(
    .EXPONENT_WIDTH (8),
    .MANTISSA_WIDTH (23),
    .DEPTH          (DEPTH),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of {flags, data}, sticky bits, saturating counts.
  logic [34:0] mq[$];
  logic [2:0]  m_sticky;
  int          m_cnt [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sticky = '0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      logic [2:0] f;
      logic       push, pop;
      f    = {bus.in_invalid, bus.in_overflow, bus.in_underflow};
      push = bus.in_valid && (mq.size() < DEPTH) && !bus.flush;
      pop  = bus.out_ready && (mq.size() > 0) && !bus.flush;
      if (bus.flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({f, bus.in_data});
      end
      if (bus.clear_flags) begin
        m_sticky = '0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end
      if (push) begin
        m_sticky = m_sticky | f;
        for (int i = 0; i < 3; i++)
          if (f[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("cyc_in_ready", bus.in_ready, mq.size() < DEPTH);
      check("cyc_out_valid", bus.out_valid, mq.size() > 0);
      check("cyc_level", bus.level, mq.size());
      check("cyc_sticky", bus.sticky_flags, m_sticky);
      if (mq.size() > 0) begin
        check("cyc_out_data", bus.out_data, mq[0][31:0]);
        check("cyc_out_flags", bus.out_flags, mq[0][34:32]);
      end
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
      check("cyc_unf_cnt", bus.underflow_count, m_cnt[0]);
      check("cyc_ovf_cnt", bus.overflow_count, m_cnt[1]);
      check("cyc_inv_cnt", bus.invalid_count, m_cnt[2]);
`endif
    end
  end

  // Drive one cycle of inputs at negedge; return just after the sampling edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [2:0] f,
                     input logic ordy, input logic fl, input logic clr);
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.in_invalid   = f[2];
    bus.in_overflow  = f[1];
    bus.in_underflow = f[0];
    bus.out_ready    = ordy;
    bus.flush        = fl;
    bus.clear_flags  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_invalid = 0; bus.in_overflow = 0;
    bus.in_underflow = 0; bus.out_ready = 0; bus.flush = 0; bus.clear_flags = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", bus.level, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sticky", bus.sticky_flags, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // first push: visible one edge later
    cyc(1'b1, 32'h3F800000, 3'b000, 1'b0, 1'b0, 1'b0);
    check("first_valid", bus.out_valid, 1);
    check("first_data", bus.out_data, 32'h3F800000);
    check("first_level", bus.level, 1);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    check("first_pop_level", bus.level, 0);

    // fill, refused push with same-cycle pop, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h40000000 + i, 3'b000, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", bus.in_ready, 0);
    check("full_level", bus.level, 4);
    cyc(1'b1, 32'h40000004, 3'b000, 1'b1, 1'b0, 1'b0);
    check("refused_level", bus.level, 3);
    for (int j = 0; j < 3; j++) begin
      check("drain_order", bus.out_data, 32'h40000001 + j);
      cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    end
    check("drained_valid", bus.out_valid, 0);

    // sticky flags accumulate on push, survive pop, clear on request
    cyc(1'b1, 32'h7FC00000, 3'b100, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h7F800000, 3'b010, 1'b0, 1'b0, 1'b0);
    check("sticky_after_push", bus.sticky_flags, 3'b110);
    check("head_flags_invalid", bus.out_flags, 3'b100);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    check("head_flags_overflow", bus.out_flags, 3'b010);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    check("sticky_after_pop", bus.sticky_flags, 3'b110);
    cyc(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("sticky_cleared", bus.sticky_flags, 3'b000);

    // clear together with an underflow push: new flag survives
    cyc(1'b1, 32'h00000001, 3'b001, 1'b0, 1'b0, 1'b1);
    check("clr_push_sticky", bus.sticky_flags, 3'b001);
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
    check("clr_push_unf_cnt", bus.underflow_count, 1);
    check("clr_push_inv_cnt", bus.invalid_count, 0);
`endif
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    // flush with a simultaneous flagged push: push dropped, sticky untouched
    cyc(1'b1, 32'h00000011, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000022, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000033, 3'b000, 1'b0, 1'b0, 1'b0);
    check("pre_flush_level", bus.level, 3);
    cyc(1'b1, 32'h0000DEAD, 3'b010, 1'b1, 1'b1, 1'b0);
    check("flush_level", bus.level, 0);
    check("flush_valid", bus.out_valid, 0);
    check("flush_sticky", bus.sticky_flags, 3'b001);
    cyc(1'b1, 32'h00000044, 3'b000, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", bus.out_data, 32'h00000044);
    check("post_flush_level", bus.level, 1);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    // streaming invalid pushes: full throughput, counter saturates
    for (int k = 0; k < 20; k++) cyc(1'b1, 32'h7FC00000 + k, 3'b100, 1'b1, 1'b0, 1'b0);
    check("stream_level", bus.level, 1);
    check("stream_head", bus.out_data, 32'h7FC00013);
    check("stream_sticky", bus.sticky_flags, 3'b101);
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
    check("inv_cnt_sat", bus.invalid_count, 15);
    check("unf_cnt_kept", bus.underflow_count, 1);
`endif
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);

    // asynchronous reset mid-stream
    cyc(1'b1, 32'h00000055, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000066, 3'b010, 1'b0, 1'b0, 1'b0);
    idle();
    check("pre_rst_level", bus.level, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", bus.level, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_sticky", bus.sticky_flags, 3'b000);
`ifdef FLOAT_RESULT_BUFFER_COUNTERS_EN
    check("arst_inv_cnt", bus.invalid_count, 0);
    check("arst_ovf_cnt", bus.overflow_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h00000077, 3'b000, 1'b0, 1'b0, 1'b0);
    check("post_rst_head", bus.out_data, 32'h00000077);
    check("post_rst_level", bus.level, 1);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
